alu_flag_stage: RTL and testbench
=================================

Name: alu_flag_stage

Overview:
- Execute-side stage directly downstream of the 64-bit ALU: accepts one ALU result plus its negative/zero/overflow/carry_out flags per beat over a valid/ready handshake.
- Holds the architectural NZCV flag register, which is updated only on flag-setting operations.
- Resolves branch-taken for B, B.cond and CBZ, and buffers each beat in a 2-entry FIFO for the memory/writeback consumer.

Parameters:
WIDTH, 64, datapath width of ALU result
DEPTH, 2, output buffer entries (fixed at 2; other values unsupported)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  upstream beat present
in_ready  output  1  stage can accept a beat this cycle
result  input  WIDTH  ALU result
negative  input  1  ALU negative flag
zero  input  1  ALU zero flag
overflow  input  1  ALU overflow flag
carry_out  input  1  ALU carry-out flag
set_flags  input  1  beat is a flag-setting op (ADDS/SUBS)
br_type  input  2  00 none, 01 unconditional B, 10 B.cond, 11 CBZ
cond  input  4  condition code for B.cond
out_valid  output  1  head-of-buffer beat present
out_ready  input  1  downstream accepts head beat
out_result  output  WIDTH  buffered result
out_flags  output  4  {N,Z,C,V} from the ALU for this beat
out_taken  output  1  branch decision for this beat
flags_q  output  4  architectural {N,Z,C,V} register

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low; asserting it low immediately clears all state.
- Reset values:
  - out_valid=0, out_result=0, out_flags=0, out_taken=0.
  - flags_q=4'b0000, buffer count=0, in_ready=1 once reset is released.
- Handshake:
  - Input accept when in_valid & in_ready.
  - Output pop when out_valid & out_ready.
  - in_ready = (count < 2). It is registered-state based and does not depend on out_ready combinationally.
- Latency: an accepted beat is visible on the out_* ports the following cycle when the buffer was empty. Order is strictly FIFO.
- Count update per cycle:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, with the head advancing and the new beat written to the tail.
  - With count=2, no push occurs even if out_ready=1 in that cycle.
- Flag register: on accept with set_flags=1, flags_q <= {negative, zero, carry_out, overflow}. Otherwise it holds. Non-accepted cycles never change flags_q.
- out_taken is computed at accept time and stored with the beat:
  - br_type 00 -> 0
  - br_type 01 -> 1
  - br_type 11 (CBZ) -> zero of the incoming beat
  - br_type 10 -> condition evaluated on effective flags. Effective flags are the incoming flags if set_flags=1 on the same beat, otherwise flags_q.
- Condition codes (N, Z, C, V = effective flags):
  - 0000 EQ Z; 0001 NE !Z
  - 0010 HS C; 0011 LO !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110/1111 AL 1
- out_* hold stable while out_valid=1 and out_ready=0.
- Reset mid-operation discards buffered beats and flags. No partial beat survives.
- Width: result passes through unmodified. No arithmetic is performed on it.

Decomposition:
- Shared package alu_pkg:
  - ALU cntrl constants (PASS_B 000, ADD 010, SUBTRACT 011, AND 100, OR 101, XOR 110)
  - br_type enum
  - cond_t 4-bit enum
  - flags_t packed struct {n,z,c,v}
- One sub-module: cond_eval (combinational; flags_t + cond -> taken), reused by the fetch/branch logic.

Test Plan:
- Reset then release, out_ready=1: push result=0x5, flags 0000, br_type 00 -> next cycle out_valid=1, out_result=0x5, out_taken=0, flags_q=0000.
- Push SUBS of 0xFFFF_FFFF_FFFF_FFFF−0xFFFF_FFFF_FFFF_FFFF (result 0, Z=1, C=1, set_flags=1), then B.cond EQ -> flags_q=0110, branch out_taken=1. Then B.cond NE -> 0.
- Same beat set_flags=1, br_type=10, cond LT, N=1, V=0 -> out_taken=1 and flags_q=1000 the next cycle.
- out_ready=0: push 3 beats back-to-back -> in_ready falls after the 2nd accept. Then out_ready=1 -> beats pop in order, in_ready returns to 1.
- CBZ beat with result=0 -> out_taken=1; with result=0x1 -> 0. flags_q is unchanged (set_flags=0).
- Assert reset low with 2 beats buffered and flags_q=1111 -> out_valid=0 and flags_q=0000 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-side ALU path.
//   - ALU control encodings
//   - branch type and condition code enums
//   - packed {n,z,c,v} flag struct
package alu_pkg;

   localparam logic [2:0] ALU_PASS_B   = 3'b000;
   localparam logic [2:0] ALU_ADD      = 3'b010;
   localparam logic [2:0] ALU_SUBTRACT = 3'b011;
   localparam logic [2:0] ALU_AND      = 3'b100;
   localparam logic [2:0] ALU_OR       = 3'b101;
   localparam logic [2:0] ALU_XOR      = 3'b110;

   typedef enum logic [1:0] {
      BR_NONE   = 2'b00,
      BR_UNCOND = 2'b01,
      BR_COND   = 2'b10,
      BR_CBZ    = 2'b11
   } br_type_e;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_HS = 4'b0010,
      COND_LO = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111   // architecturally also "always"
   } cond_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator.
//   flags_i : effective {n,z,c,v}
//   cond_i  : 4-bit condition code
//   taken_o : 1 when the condition holds
module cond_eval
   import alu_pkg::*;
(
   input  flags_t flags_i,
   input  cond_t  cond_i,
   output logic   taken_o
);

   logic n_eq_v;
   assign n_eq_v = (flags_i.n == flags_i.v);

   always_comb begin
      taken_o = 1'b1;
      case (cond_i)
         COND_EQ: taken_o =  flags_i.z;
         COND_NE: taken_o = !flags_i.z;
         COND_HS: taken_o =  flags_i.c;
         COND_LO: taken_o = !flags_i.c;
         COND_MI: taken_o =  flags_i.n;
         COND_PL: taken_o = !flags_i.n;
         COND_VS: taken_o =  flags_i.v;
         COND_VC: taken_o = !flags_i.v;
         COND_HI: taken_o =  flags_i.c && !flags_i.z;
         COND_LS: taken_o = !flags_i.c ||  flags_i.z;
         COND_GE: taken_o =  n_eq_v;
         COND_LT: taken_o = !n_eq_v;
         COND_GT: taken_o = !flags_i.z &&  n_eq_v;
         COND_LE: taken_o =  flags_i.z || !n_eq_v;
         default: taken_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_flag_stage.sv
// ALU flag stage: takes one ALU result + flags per beat, maintains the
// architectural NZCV register, resolves branch-taken at accept time and
// buffers each beat in a 2-entry FIFO for the downstream consumer.
//   clk, reset(active-low async)
//   in_valid/in_ready, result, negative/zero/overflow/carry_out,
//   set_flags, br_type, cond                 : upstream beat
//   out_valid/out_ready, out_result,
//   out_flags, out_taken                     : head of buffer
//   flags_q                                  : architectural {N,Z,C,V}
module alu_flag_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] result,
   input  logic             negative,
   input  logic             zero,
   input  logic             overflow,
   input  logic             carry_out,
   input  logic             set_flags,
   input  logic [1:0]       br_type,
   input  logic [3:0]       cond,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic             out_taken,
   output logic [3:0]       flags_q
);

   localparam logic [1:0] DEPTH_C = 2'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      flags_t           flags;
      logic             taken;
   } entry_t;

   entry_t     mem_q [2];
   logic       wr_ptr_q, rd_ptr_q;
   logic [1:0] count_q, count_d;
   flags_t     flag_reg_q;

   logic   push, pop;
   flags_t in_flags, eff_flags;
   logic   cond_taken, taken_d;
   entry_t head;

   assign in_ready  = (count_q < DEPTH_C);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign in_flags  = '{n: negative, z: zero, c: carry_out, v: overflow};
   // A flag-setting B.cond sees its own flags, not the stale register.
   assign eff_flags = set_flags ? in_flags : flag_reg_q;

   cond_eval u_cond_eval (
      .flags_i (eff_flags),
      .cond_i  (cond_t'(cond)),
      .taken_o (cond_taken)
   );

   always_comb begin
      taken_d = 1'b0;
      case (br_type_e'(br_type))
         BR_NONE:   taken_d = 1'b0;
         BR_UNCOND: taken_d = 1'b1;
         BR_COND:   taken_d = cond_taken;
         BR_CBZ:    taken_d = zero;
         default:   taken_d = 1'b0;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         flag_reg_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= '{result: result, flags: in_flags, taken: taken_d};
            wr_ptr_q        <= ~wr_ptr_q;
            if (set_flags) flag_reg_q <= in_flags;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_d;
      end
   end

   // Outputs read zero while the buffer is empty.
   assign head       = mem_q[rd_ptr_q];
   assign out_result = out_valid ? head.result : '0;
   assign out_flags  = out_valid ? head.flags  : 4'b0000;
   assign out_taken  = out_valid ? head.taken  : 1'b0;
   assign flags_q    = flag_reg_q;

endmodule

// File: tb/tb_alu_flag_stage.sv
module tb_alu_flag_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [63:0] result;
   logic        negative, zero, overflow, carry_out, set_flags;
   logic [1:0]  br_type;
   logic [3:0]  cond;
   logic        out_valid, out_ready;
   logic [63:0] out_result;
   logic [3:0]  out_flags;
   logic        out_taken;
   logic [3:0]  flags_q;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: queue of {result, nzcv, taken} and the NZCV register
   logic [68:0] mq[$];
   logic [3:0]  m_flags;

   always #5 clk = ~clk;

   alu_flag_stage #(.WIDTH(64), .DEPTH(2)) dut (
      .clk(clk), .reset(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .result(result), .negative(negative), .zero(zero),
      .overflow(overflow), .carry_out(carry_out),
      .set_flags(set_flags), .br_type(br_type), .cond(cond),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags),
      .out_taken(out_taken), .flags_q(flags_q)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic m_cond(input logic [3:0] f, input logic [3:0] cc);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cc)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   task automatic check_all(input string where);
      logic [68:0] h;
      chk({where, ".out_valid"}, out_valid, mq.size() != 0);
      chk({where, ".in_ready"},  in_ready,  mq.size() < 2);
      chk({where, ".flags_q"},   flags_q,   m_flags);
      if (mq.size() != 0) begin
         h = mq[0];
         chk({where, ".out_result"}, out_result, h[68:5]);
         chk({where, ".out_flags"},  out_flags,  h[4:1]);
         chk({where, ".out_taken"},  out_taken,  h[0]);
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, check after.
   task automatic cycle(input string where, input logic v, input logic [63:0] r,
                        input logic [3:0] nzcv, input logic sf, input logic [1:0] bt,
                        input logic [3:0] cc, input logic ordy);
      logic acc, pp, tk;
      logic [3:0] eff;
      in_valid = v; result = r;
      {negative, zero, carry_out, overflow} = nzcv;
      set_flags = sf; br_type = bt; cond = cc; out_ready = ordy;
      acc = v && (mq.size() < 2);
      pp  = ordy && (mq.size() != 0);
      @(posedge clk);
      if (pp) void'(mq.pop_front());
      if (acc) begin
         eff = sf ? nzcv : m_flags;
         case (bt)
            2'b00:   tk = 1'b0;
            2'b01:   tk = 1'b1;
            2'b10:   tk = m_cond(eff, cc);
            default: tk = nzcv[2];
         endcase
         mq.push_back({r, nzcv, tk});
         if (sf) m_flags = nzcv;
      end
      #1;
      check_all(where);
   endtask

   task automatic idle(input string where, input logic ordy);
      cycle(where, 1'b0, 64'h0, 4'h0, 1'b0, 2'b00, 4'h0, ordy);
   endtask

   initial begin
      logic [63:0] r;
      logic [3:0]  f;
      rst_n = 1'b0;
      in_valid = 0; result = '0; negative = 0; zero = 0; overflow = 0; carry_out = 0;
      set_flags = 0; br_type = 0; cond = 0; out_ready = 0;
      m_flags = 4'h0;
      #23;
      chk("rst.out_valid", out_valid, 1'b0);
      chk("rst.out_result", out_result, 64'h0);
      chk("rst.out_flags", out_flags, 4'h0);
      chk("rst.out_taken", out_taken, 1'b0);
      chk("rst.flags_q", flags_q, 4'h0);
      rst_n = 1'b1;
      #1;
      chk("rst.in_ready", in_ready, 1'b1);

      // simple beat, visible next cycle
      cycle("t1", 1, 64'h5, 4'b0000, 0, 2'b00, 4'h0, 1);
      chk("t1.result", out_result, 64'h5);
      chk("t1.valid", out_valid, 1'b1);
      idle("t1.drain", 1);

      // SUBS all-ones minus all-ones: Z=1 C=1, then B.cond EQ / NE
      cycle("t2.subs", 1, 64'h0, 4'b0110, 1, 2'b00, 4'h0, 1);
      chk("t2.flags_q", flags_q, 4'b0110);
      cycle("t2.eq", 1, 64'h10, 4'b0000, 0, 2'b10, 4'h0, 1);
      chk("t2.eq_taken", out_taken, 1'b1);
      cycle("t2.ne", 1, 64'h11, 4'b0000, 0, 2'b10, 4'h1, 1);
      chk("t2.ne_taken", out_taken, 1'b0);
      idle("t2.drain", 1);

      // flag-setting B.cond LT uses its own flags
      cycle("t3.lt", 1, 64'h8000_0000_0000_0000, 4'b1000, 1, 2'b10, 4'hB, 1);
      chk("t3.lt_taken", out_taken, 1'b1);
      chk("t3.flags_q", flags_q, 4'b1000);
      idle("t3.drain", 1);

      // back-pressure: 3 beats with out_ready=0
      cycle("t4.b0", 1, 64'hA0, 4'b0000, 0, 2'b01, 4'h0, 0);
      cycle("t4.b1", 1, 64'hA1, 4'b0000, 0, 2'b00, 4'h0, 0);
      chk("t4.full_in_ready", in_ready, 1'b0);
      cycle("t4.b2", 1, 64'hA2, 4'b0000, 0, 2'b00, 4'h0, 0);
      chk("t4.hold_result", out_result, 64'hA0);
      idle("t4.pop0", 1);
      chk("t4.pop0_result", out_result, 64'hA1);
      idle("t4.pop1", 1);
      chk("t4.empty_ready", in_ready, 1'b1);

      // CBZ
      cycle("t5.cbz0", 1, 64'h0, 4'b0100, 0, 2'b11, 4'h0, 1);
      chk("t5.cbz0_taken", out_taken, 1'b1);
      cycle("t5.cbz1", 1, 64'h1, 4'b0000, 0, 2'b11, 4'h0, 1);
      chk("t5.cbz1_taken", out_taken, 1'b0);
      chk("t5.flags_hold", flags_q, 4'b1000);
      idle("t5.drain", 1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom(), $urandom()};
         f = {r[63], (r == 64'h0), 1'($urandom()), 1'($urandom())};
         cycle("rand", ($urandom_range(0, 3) != 0), r, f, 1'($urandom()),
               2'($urandom()), 4'($urandom()), 1'($urandom()));
      end

      // asynchronous reset with two beats buffered and flags 1111
      idle("t6.drain0", 1);
      idle("t6.drain1", 1);
      cycle("t6.b0", 1, 64'hC0, 4'b1111, 1, 2'b00, 4'h0, 0);
      cycle("t6.b1", 1, 64'hC1, 4'b1111, 1, 2'b00, 4'h0, 0);
      chk("t6.pre_flags", flags_q, 4'b1111);
      chk("t6.pre_full", in_ready, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6.rst_valid", out_valid, 1'b0);
      chk("t6.rst_flags", flags_q, 4'b0000);
      chk("t6.rst_result", out_result, 64'h0);
      mq.delete();
      m_flags = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      idle("t6.after", 1);
      cycle("t6.new", 1, 64'hD0, 4'b0001, 1, 2'b00, 4'h0, 1);
      idle("t6.end", 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
